tdnn_delay_line: RTL and testbench
==================================

# tdnn_delay_line

Time-delay tap buffer that sits directly upstream of the neuron stage in the TDNN datapath. It accepts a serial stream of signed Q1.15 samples through a valid/ready handshake and shifts them into a NUM_INPUTS-deep window. Once the window is full, it presents the window as a parallel tap vector that drives the neuron's input array. Windows are emitted every STRIDE accepted samples, and the buffer holds under backpressure so no window is lost.

## Interface
Parameters:
- SIG_SIZE, 16, sample width (signed, Q1.15); must match the neuron input width
- NUM_INPUTS, 3, window depth; ≥ 2
- STRIDE, 1, accepted samples between successive windows once full; ≥ 1
- CNT_W, 16, width of WINDOW_COUNT

Ports:
- CLOCK_N  in  1  clock; all state updates on the falling edge
- RESET_N  in  1  reset; asynchronous, active-low
- SAMPLE_IN  in  SIG_SIZE signed  incoming sample
- SAMPLE_VALID  in  1  SAMPLE_IN is valid this cycle
- SAMPLE_READY  out  1  block will accept a sample at the next falling edge
- FLUSH  in  1  synchronous clear of the window
- TAPS_OUT  out  SIG_SIZE signed × NUM_INPUTS  tap vector; [0] newest, [NUM_INPUTS-1] oldest
- TAPS_VALID  out  1  TAPS_OUT holds a complete, unconsumed window
- TAPS_ACCEPT  in  1  downstream consumes the window at the next falling edge
- FILL_COUNT  out  $clog2(NUM_INPUTS+1)  valid taps in the window, 0..NUM_INPUTS
- WINDOW_COUNT  out  CNT_W  windows emitted since reset/flush; wraps modulo 2^CNT_W

## Operation
- TAPS_OUT is the shift register itself, with no separate output copy. Its contents are stable while no sample is accepted.
- SAMPLE_READY = !FLUSH && (!TAPS_VALID || TAPS_ACCEPT). This is combinational, with no dependence on SAMPLE_VALID.
- A sample is accepted when SAMPLE_VALID && SAMPLE_READY at a falling edge. On accept:
  - taps shift (tap[i] ← tap[i-1], tap[0] ← SAMPLE_IN)
  - FILL_COUNT increments, saturating at NUM_INPUTS
- Stride counter sc (0..STRIDE-1):
  - A window forms on an accept when the post-shift FILL_COUNT == NUM_INPUTS and either (a) the pre-shift FILL_COUNT was NUM_INPUTS-1 (first fill), or (b) sc == STRIDE-1.
  - On window formation, sc ← 0.
  - On any other accept while full, sc ← sc+1.
  - sc holds while not full.
- TAPS_VALID update at each falling edge:
  - set if a window forms
  - else cleared if TAPS_ACCEPT
  - else held
  - Simultaneous TAPS_ACCEPT and window formation leaves TAPS_VALID high, presenting the new window.
- WINDOW_COUNT increments on each window formation and wraps from 2^CNT_W-1 to 0.
- TAPS_ACCEPT while TAPS_VALID is low is ignored.
- FLUSH has highest priority. At the falling edge with FLUSH high:
  - all taps ← 0
  - FILL_COUNT, sc, TAPS_VALID and WINDOW_COUNT ← 0
  - no sample is accepted, since SAMPLE_READY is low
  - a pending window is discarded even if TAPS_ACCEPT is high
- No arithmetic is applied to samples; they pass through bit-exact.

## Timing
- Reset (RESET_N low, any time, asynchronous) forces:
  - TAPS_OUT = 0, TAPS_VALID = 0, FILL_COUNT = 0, WINDOW_COUNT = 0, sc = 0
  - SAMPLE_READY = 1 (follows from TAPS_VALID = 0 and FLUSH low)
- Reset mid-window discards the partial window. Release is synchronised by the team's standard reset release; the first accept can occur at the first falling edge after deassertion.
- Latency: the sample that completes a window, accepted at falling edge k, appears in TAPS_OUT[0] with TAPS_VALID high immediately after edge k. The neuron samples it at edge k+1.
- Throughput with STRIDE=1 and TAPS_ACCEPT tied high is one window per cycle after the NUM_INPUTS-cycle fill.
- Backpressure: while TAPS_VALID && !TAPS_ACCEPT, SAMPLE_READY is low and TAPS_OUT is frozen. Upstream must hold SAMPLE_IN/SAMPLE_VALID.
- FILL_COUNT updates on the same edge as the shift.

## Test plan
- Reset then fill, defaults: feed 0x1000, 0x2000, 0x3000 on consecutive edges with TAPS_ACCEPT=1.
  - Required: TAPS_VALID rises after edge 3; TAPS_OUT = {[0]=0x3000, [1]=0x2000, [2]=0x1000}; FILL_COUNT = 3; WINDOW_COUNT = 1.
  - Next sample 0x4000 → taps {0x4000, 0x3000, 0x2000}; WINDOW_COUNT = 2.
- Backpressure: after the first window, hold TAPS_ACCEPT=0 for 5 cycles with SAMPLE_VALID=1.
  - Required: SAMPLE_READY=0 and TAPS_OUT unchanged for those cycles.
  - Asserting TAPS_ACCEPT with the same edge accepting 0x4000 → TAPS_VALID stays 1 and the new window is presented.
- STRIDE=2, NUM_INPUTS=3, samples 1..7, ACCEPT=1.
  - Required: windows emitted after samples 3, 5 and 7 only; TAPS_VALID low after 4 and 6; WINDOW_COUNT = 3.
- FLUSH mid-fill and with a pending window.
  - After 2 samples, FLUSH → FILL_COUNT=0 and taps 0; three more samples are needed before a window.
  - FLUSH while TAPS_VALID=1 and TAPS_ACCEPT=1 → TAPS_VALID=0 and WINDOW_COUNT=0.
- Asynchronous reset between edges while TAPS_VALID=1.
  - Required: all outputs 0 immediately, SAMPLE_READY=1.
- Signed extremes and wrap.
  - Samples 0x8000, 0x7FFF, 0xFFFF pass through bit-exact.
  - With CNT_W=2, the fifth window → WINDOW_COUNT = 1.

Source files
------------

// File: rtl/tdnn_delay_line.sv
// Time-delay tap buffer: shifts a valid/ready sample stream into a NUM_INPUTS-deep
// window and presents it as a parallel tap vector every STRIDE accepted samples.
module tdnn_delay_line #(
   parameter int SIG_SIZE   = 16,
   parameter int NUM_INPUTS = 3,
   parameter int STRIDE     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                                 CLOCK_N,
   input  logic                                 RESET_N,
   input  logic signed [SIG_SIZE-1:0]           SAMPLE_IN,
   input  logic                                 SAMPLE_VALID,
   output logic                                 SAMPLE_READY,
   input  logic                                 FLUSH,
   output logic [NUM_INPUTS-1:0][SIG_SIZE-1:0]  TAPS_OUT,
   output logic                                 TAPS_VALID,
   input  logic                                 TAPS_ACCEPT,
   output logic [$clog2(NUM_INPUTS+1)-1:0]      FILL_COUNT,
   output logic [CNT_W-1:0]                     WINDOW_COUNT
);

   localparam int FILL_W = $clog2(NUM_INPUTS + 1);
   localparam int SC_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_INPUTS);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_INPUTS - 1);
   localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(STRIDE - 1);

   logic signed [SIG_SIZE-1:0] tap_p0 [NUM_INPUTS];
   logic [FILL_W-1:0]          fill_p0;
   logic [SC_W-1:0]            sc_p0;
   logic                       vld_p0;
   logic [CNT_W-1:0]           win_cnt_p0;

   logic accept;
   logic full_now;
   logic window_form;

   function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
      return (f == FILL_FULL) ? f : f + 1'b1;
   endfunction

   assign SAMPLE_READY = !FLUSH && (!vld_p0 || TAPS_ACCEPT);
   assign accept       = SAMPLE_VALID && SAMPLE_READY;
   assign full_now     = (fill_p0 == FILL_FULL);

   // First fill always forms a window; afterwards only every STRIDE-th accept does.
   assign window_form  = accept && ((fill_p0 == FILL_LAST) || (full_now && (sc_p0 == SC_LAST)));

   // Stage p0: the shift register doubles as the output tap vector.
   always_ff @(negedge CLOCK_N or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_INPUTS; i++) tap_p0[i] <= '0;
         fill_p0    <= '0;
         sc_p0      <= '0;
         vld_p0     <= 1'b0;
         win_cnt_p0 <= '0;
      end else if (FLUSH) begin
         for (int i = 0; i < NUM_INPUTS; i++) tap_p0[i] <= '0;
         fill_p0    <= '0;
         sc_p0      <= '0;
         vld_p0     <= 1'b0;
         win_cnt_p0 <= '0;
      end else begin
         if (accept) begin
            tap_p0[0] <= SAMPLE_IN;
            for (int i = 1; i < NUM_INPUTS; i++) tap_p0[i] <= tap_p0[i-1];
            fill_p0 <= fill_sat_inc(fill_p0);
         end

         if (window_form)
            sc_p0 <= '0;
         else if (accept && full_now)
            sc_p0 <= sc_p0 + 1'b1;

         if (window_form)
            vld_p0 <= 1'b1;
         else if (TAPS_ACCEPT)
            vld_p0 <= 1'b0;

         if (window_form)
            win_cnt_p0 <= win_cnt_p0 + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_taps
      assign TAPS_OUT[g] = tap_p0[g];
   end

   assign TAPS_VALID   = vld_p0;
   assign FILL_COUNT   = fill_p0;
   assign WINDOW_COUNT = win_cnt_p0;

endmodule

// File: tb/tb_tdnn_delay_line.sv
// Bench for tdnn_delay_line: two instances (STRIDE=1/CNT_W=16 and STRIDE=2/CNT_W=2)
// share one sample stream; a history-based model feeds a window scoreboard.
module tb_tdnn_delay_line;

   localparam int N    = 3;
   localparam int HMAX = 4096;

   typedef logic [N-1:0][15:0] taps_t;
   typedef struct {
      taps_t       taps;
      int unsigned wc;
   } win_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        flush;
   logic [1:0]  acc;
   logic [1:0]  rdy;
   logic [1:0]  tv;
   taps_t       taps0, taps1;
   logic [1:0]  fill0, fill1;
   logic [15:0] wc0;
   logic [1:0]  wc1;

   int tests = 0;
   int fails = 0;

   tdnn_delay_line #(.SIG_SIZE(16), .NUM_INPUTS(N), .STRIDE(1), .CNT_W(16)) dut0 (
      .CLOCK_N(clk), .RESET_N(rst_n), .SAMPLE_IN(sample_in), .SAMPLE_VALID(sample_valid),
      .SAMPLE_READY(rdy[0]), .FLUSH(flush), .TAPS_OUT(taps0), .TAPS_VALID(tv[0]),
      .TAPS_ACCEPT(acc[0]), .FILL_COUNT(fill0), .WINDOW_COUNT(wc0));

   tdnn_delay_line #(.SIG_SIZE(16), .NUM_INPUTS(N), .STRIDE(2), .CNT_W(2)) dut1 (
      .CLOCK_N(clk), .RESET_N(rst_n), .SAMPLE_IN(sample_in), .SAMPLE_VALID(sample_valid),
      .SAMPLE_READY(rdy[1]), .FLUSH(flush), .TAPS_OUT(taps1), .TAPS_VALID(tv[1]),
      .TAPS_ACCEPT(acc[1]), .FILL_COUNT(fill1), .WINDOW_COUNT(wc1));

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Reference model: every accepted sample since the last reset/flush is kept in order.
   logic [15:0] hist [2][HMAX];
   int          m_cnt   [2];
   int          m_since [2];
   int          m_wc    [2];
   bit          m_pend  [2];
   win_t        q0[$];
   win_t        q1[$];

   function automatic int stride_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic int cmod_of(input int d);
      return (d == 0) ? 65536 : 4;
   endfunction

   function automatic int model_fill(input int d);
      return (m_cnt[d] < N) ? m_cnt[d] : N;
   endfunction

   function automatic taps_t model_taps(input int d);
      taps_t t;
      t = '0;
      for (int i = 0; i < model_fill(d); i++) t[i] = hist[d][m_cnt[d] - 1 - i];
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear(input int d);
      m_cnt[d] = 0; m_since[d] = 0; m_wc[d] = 0; m_pend[d] = 0;
      if (d == 0) q0.delete(); else q1.delete();
   endtask

   task automatic model_edge(input int d);
      bit   accept;
      bit   formed;
      win_t w;
      if (flush) begin
         model_clear(d);
         return;
      end
      accept = sample_valid && (!m_pend[d] || acc[d]);
      formed = 0;
      if (accept) begin
         hist[d][m_cnt[d]] = sample_in;
         m_cnt[d]++;
         if (m_cnt[d] == N) formed = 1;
         else if (m_cnt[d] > N) begin
            m_since[d]++;
            if (m_since[d] == stride_of(d)) formed = 1;
         end
      end
      if (formed) begin
         m_since[d] = 0;
         m_wc[d]    = (m_wc[d] + 1) % cmod_of(d);
         m_pend[d]  = 1;
         w.taps     = model_taps(d);
         w.wc       = m_wc[d];
         if (d == 0) q0.push_back(w); else q1.push_back(w);
      end else if (acc[d]) begin
         m_pend[d] = 0;
      end
   endtask

   task automatic check_status(input int d);
      logic [63:0] a_taps, a_fill, a_wc;
      bit          exp_rdy;
      if (d == 0) begin
         a_taps = 64'(taps0); a_fill = 64'(fill0); a_wc = 64'(wc0);
      end else begin
         a_taps = 64'(taps1); a_fill = 64'(fill1); a_wc = 64'(wc1);
      end
      exp_rdy = !flush && (!m_pend[d] || acc[d]);
      chk($sformatf("d%0d taps", d),   a_taps, 64'(model_taps(d)));
      chk($sformatf("d%0d fill", d),   a_fill, 64'(model_fill(d)));
      chk($sformatf("d%0d tvalid", d), 64'(tv[d]), 64'(m_pend[d]));
      chk($sformatf("d%0d wcount", d), a_wc, 64'(m_wc[d]));
      chk($sformatf("d%0d ready", d),  64'(rdy[d]), 64'(exp_rdy));
   endtask

   task automatic cycle(input logic [15:0] s, input bit v, input bit f, input bit a0, input bit a1);
      @(posedge clk);
      #1;
      sample_in = s; sample_valid = v; flush = f; acc = {a1, a0};
      @(negedge clk);
      model_edge(0);
      model_edge(1);
      #2;
      check_status(0);
      check_status(1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      sample_valid = 1'b0; flush = 1'b0; acc = 2'b11;
      #1;
      rst_n = 1'b0;
      #1;
      model_clear(0);
      model_clear(1);
      chk("rst taps0", 64'(taps0), 64'd0);
      chk("rst taps1", 64'(taps1), 64'd0);
      chk("rst tvalid", 64'(tv), 64'd0);
      chk("rst fill", 64'({fill1, fill0}), 64'd0);
      chk("rst wcount", 64'({wc1, wc0}), 64'd0);
      chk("rst ready", 64'(rdy), 64'd3);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: a window is compared when the DUT hands it to the consumer.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (rst_n && !flush) begin
            for (int d = 0; d < 2; d++) begin
               if (tv[d] && acc[d]) begin
                  win_t w;
                  bit   got;
                  got = 0;
                  if (d == 0) begin
                     if (q0.size() > 0) begin w = q0.pop_front(); got = 1; end
                  end else begin
                     if (q1.size() > 0) begin w = q1.pop_front(); got = 1; end
                  end
                  if (!got) begin
                     tests++;
                     fails++;
                     $display("FAIL d%0d window: got a presented window, expected none", d);
                  end else begin
                     chk($sformatf("d%0d win taps", d), (d == 0) ? 64'(taps0) : 64'(taps1), 64'(w.taps));
                     chk($sformatf("d%0d win count", d), (d == 0) ? 64'(wc0) : 64'(wc1), 64'(w.wc));
                  end
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; flush = 1'b0; acc = 2'b11;
      model_clear(0);
      model_clear(1);
      do_reset();

      // Fill with defaults, then one more sample
      cycle(16'h1000, 1, 0, 1, 1);
      cycle(16'h2000, 1, 0, 1, 1);
      chk("fill not yet valid", 64'(tv[0]), 64'd0);
      cycle(16'h3000, 1, 0, 1, 1);
      chk("fill1 taps", 64'(taps0), 64'h1000_2000_3000);
      chk("fill1 tvalid", 64'(tv[0]), 64'd1);
      chk("fill1 fill", 64'(fill0), 64'd3);
      chk("fill1 wcount", 64'(wc0), 64'd1);
      cycle(16'h4000, 1, 0, 1, 1);
      chk("fill2 taps", 64'(taps0), 64'h2000_3000_4000);
      chk("fill2 wcount", 64'(wc0), 64'd2);

      // Backpressure after the first window
      do_reset();
      cycle(16'h1000, 1, 0, 1, 1);
      cycle(16'h2000, 1, 0, 1, 1);
      cycle(16'h3000, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(16'h4000, 1, 0, 0, 0);
         chk("bp ready", 64'(rdy[0]), 64'd0);
         chk("bp taps frozen", 64'(taps0), 64'h1000_2000_3000);
      end
      cycle(16'h4000, 1, 0, 1, 1);
      chk("bp release tvalid", 64'(tv[0]), 64'd1);
      chk("bp release taps", 64'(taps0), 64'h2000_3000_4000);

      // Stride 2 on dut1, and CNT_W=2 wrap on the fifth window
      do_reset();
      for (int s = 1; s <= 11; s++) begin
         cycle(16'(s), 1, 0, 1, 1);
         if (s >= 3) chk($sformatf("stride tvalid after %0d", s), 64'(tv[1]), 64'(s % 2));
         if (s == 7) chk("stride wcount", 64'(wc1), 64'd3);
      end
      chk("wrap wcount", 64'(wc1), 64'd1);

      // Flush mid-fill, then flush with a pending window being accepted
      do_reset();
      cycle(16'h0111, 1, 0, 1, 1);
      cycle(16'h0222, 1, 0, 1, 1);
      cycle(16'h0333, 1, 1, 1, 1);
      chk("flush fill", 64'(fill0), 64'd0);
      chk("flush taps", 64'(taps0), 64'd0);
      cycle(16'h0444, 1, 0, 1, 1);
      cycle(16'h0555, 1, 0, 1, 1);
      chk("flush refill pending", 64'(tv[0]), 64'd0);
      cycle(16'h0666, 1, 0, 1, 1);
      chk("flush refill valid", 64'(tv[0]), 64'd1);
      cycle(16'h0777, 1, 1, 1, 1);
      chk("flush pending tvalid", 64'(tv[0]), 64'd0);
      chk("flush pending wcount", 64'(wc0), 64'd0);

      // Asynchronous reset while a window is presented
      cycle(16'h0aaa, 1, 0, 1, 1);
      cycle(16'h0bbb, 1, 0, 1, 1);
      cycle(16'h0ccc, 1, 0, 0, 0);
      chk("pre-reset tvalid", 64'(tv[0]), 64'd1);
      do_reset();

      // Signed extremes pass through bit-exact
      cycle(16'h8000, 1, 0, 1, 1);
      cycle(16'h7FFF, 1, 0, 1, 1);
      cycle(16'hFFFF, 1, 0, 1, 1);
      chk("extremes taps", 64'(taps0), 64'h8000_7FFF_FFFF);

      // Randomized traffic with random backpressure, flushes and resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle(16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
               $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      end

      for (int i = 0; i < 4; i++) cycle(16'h0000, 0, 0, 1, 1);
      @(posedge clk);
      #4;
      chk("d0 leftover windows", 64'(q0.size()), 64'd0);
      chk("d1 leftover windows", 64'(q1.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
